// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction-fetch front end. Holds the PC, issues in-order
//            requests to instruction memory over valid/ready, buffers the
//            returned words together with their PCs and hands them to decode.
//            Redirects flush the buffer and discard responses still in flight.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk             in   rising-edge clock
//   rst             in   asynchronous active-low reset
//   redirect_valid  in   one-cycle redirect pulse
//   redirect_pc     in   redirect target (bits [1:0] ignored)
//   imem_req_valid  out  fetch request valid
//   imem_req_ready  in   memory accepts request
//   imem_req_addr   out  fetch address
//   imem_rsp_valid  in   in-order response valid
//   imem_rsp_data   in   instruction word
//   inst_valid      out  instruction available to decode
//   inst_ready      in   decode consumes instruction
//   inst            out  instruction at buffer head
//   inst_pc         out  PC of inst
//   perf_fetch_cnt  out  buffer pops           (FETCH_PERF_EN only)
//   perf_flush_cnt  out  responses discarded   (FETCH_PERF_EN only)
// Optional feature macro: FETCH_PERF_EN
// ============================================================================
module fetch_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h80000000,
  parameter int unsigned     BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_flush_cnt
`endif
);

  localparam int unsigned     AW         = $clog2(BUF_DEPTH);
  localparam int unsigned     CW         = AW + 1;
  localparam logic [CW-1:0]   DEPTH_C    = CW'(BUF_DEPTH);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic [CW-1:0]     drop_q, drop_d;
  logic [CW-1:0]     count_q, count_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [31:0]       buf_data_q [BUF_DEPTH];
  logic [31:0]       buf_data_d [BUF_DEPTH];
  logic [XLEN-1:0]   buf_pc_q   [BUF_DEPTH];
  logic [XLEN-1:0]   buf_pc_d   [BUF_DEPTH];

  logic              req_fire;
  logic              pop;
  logic              rsp_drop;
  logic              rsp_take;
  logic [CW-1:0]     out_next;
  logic [CW-1:0]     drop_next;
  logic [XLEN-1:0]   rsp_pc;

  // Credit rule: requests in flight plus buffered words never exceed the
  // buffer size, so every accepted response has a slot waiting for it.
  assign imem_req_valid = (state_q == ST_RUN) && ((outstanding_q + count_q) < DEPTH_C);
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (count_q != '0);
  assign inst           = buf_data_q[rd_ptr_q];
  assign inst_pc        = buf_pc_q[rd_ptr_q];

  assign req_fire = imem_req_valid && imem_req_ready;
  assign pop      = inst_valid && inst_ready;
  assign rsp_drop = imem_rsp_valid && (drop_q != '0);
  assign rsp_take = imem_rsp_valid && (drop_q == '0) && (outstanding_q != '0);

  // Outstanding requests are the most recent consecutive fetches since the
  // last redirect, so the oldest one (the one answering now) sits
  // 4*outstanding bytes behind the current PC.
  assign rsp_pc = pc_q - (XLEN'(outstanding_q) << 2);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    buf_data_d    = buf_data_q;
    buf_pc_d      = buf_pc_q;

    out_next  = outstanding_q + CW'(req_fire) - CW'(rsp_take);
    drop_next = drop_q - CW'(rsp_drop);

    if (state_q == ST_WAIT) begin
      state_d = ST_RUN;
      if (redirect_valid) begin
        pc_d = redirect_pc & ALIGN_MASK;
      end
    end else if (redirect_valid) begin
      // Everything in flight at the end of this cycle becomes garbage,
      // including a request accepted right now; a response consumed now is
      // simply not pushed.
      pc_d          = redirect_pc & ALIGN_MASK;
      count_d       = '0;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      outstanding_d = '0;
      drop_d        = drop_next + out_next;
      state_d       = ((state_q == ST_FLUSH) || (drop_d != '0)) ? ST_FLUSH : ST_RUN;
    end else begin
      if (req_fire) begin
        pc_d = pc_q + XLEN'(4);
      end
      outstanding_d = out_next;
      drop_d        = drop_next;
      if (rsp_take) begin
        buf_data_d[wr_ptr_q] = imem_rsp_data;
        buf_pc_d[wr_ptr_q]   = rsp_pc;
        wr_ptr_d             = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(rsp_take) - CW'(pop);
      if ((state_q == ST_FLUSH) && (drop_q == '0)) begin
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_WAIT;
      pc_q          <= RESET_VEC;
      outstanding_q <= '0;
      drop_q        <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        buf_data_q[i] <= '0;
        buf_pc_q[i]   <= '0;
      end
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      buf_data_q    <= buf_data_d;
      buf_pc_q      <= buf_pc_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + 32'(pop);
    flush_cnt_d = flush_cnt_q + 32'(rsp_drop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction-fetch front end for the NPC core. It holds the PC and issues in-order requests to instruction memory over a valid/ready handshake, tolerating any response latency of 1 or more cycles. Returned instructions are buffered and delivered to decode with the PC of each. Branch/jump redirects flush in-flight work, so the fixed +4 single-cycle PC path is no longer needed.

Parameters:
XLEN, 32, address/PC width
RESET_VEC, 32'h80000000, first fetch address after reset (width XLEN)
BUF_DEPTH, 2, instruction buffer entries; also the maximum number of outstanding requests; power of two, at least 2

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
redirect_valid  in  1  one-cycle pulse: take redirect_pc
redirect_pc  in  XLEN  new PC; bits[1:0] are forced to 0
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts the request
imem_req_addr  out  XLEN  fetch address
imem_rsp_valid  in  1  response valid (in order; no backpressure)
imem_rsp_data  in  32  instruction word
inst_valid  out  1  instruction available to decode
inst_ready  in  1  decode consumes the instruction
inst  out  32  instruction, from the buffer head
inst_pc  out  XLEN  PC of inst

Behaviour:
- Reset (rst=0): pc_q=RESET_VEC; state=WAIT; buffer empty; outstanding=0; drop=0; imem_req_valid=0; inst_valid=0; inst=0; inst_pc=0.
- FSM states: WAIT, RUN, FLUSH.
- WAIT: lasts exactly one cycle after rst deasserts, then goes to RUN. No request is issued in WAIT.
- RUN issue condition: imem_req_valid=1 when outstanding+occupancy < BUF_DEPTH, with imem_req_addr=pc_q.
- On request handshake: pc_q += 4, wrapping modulo 2^XLEN; outstanding++.
- Response: an imem_rsp_valid with drop=0 pushes {data, pc} into the buffer and decrements outstanding. A response with drop>0 is discarded and decrements drop.
- The credit rule guarantees the buffer never overflows. A response arriving with zero outstanding and zero drop is a protocol error and is ignored.
- Pop: occurs when inst_valid and inst_ready are both 1. Push and pop in the same cycle are allowed, including when the buffer is full or empty.
- Latency: the earliest inst_valid is the cycle after the response. inst/inst_pc are held stable while inst_valid=1 and inst_ready=0.
- Redirect, any state except WAIT:
  - pc_q is set to redirect_pc with the low bits cleared.
  - The buffer is emptied and inst_valid falls next cycle.
  - drop gets the outstanding count as of the end of the cycle, including a request accepted in the same cycle and excluding a response consumed in the same cycle. outstanding is set to 0.
  - If drop>0, go to FLUSH; else stay in RUN.
  - An unaccepted pending request is withdrawn: imem_req_valid may fall without a handshake on redirect only.
- Redirect during WAIT: pc_q is updated and the state still moves to RUN.
- FLUSH: no requests are issued and no pushes occur. Go to RUN in the cycle after drop reaches 0. A redirect in FLUSH updates pc_q and stays in FLUSH.
- imem_req_addr is held stable while imem_req_valid=1 and no handshake or redirect has occurred.
- Asynchronous reset mid-operation: all state returns to reset values immediately. Responses still in flight from before reset are the memory's responsibility.

Optional Feature:
FETCH_PERF_EN.
- Defined: adds outputs perf_fetch_cnt (32) and perf_flush_cnt (32).
  - perf_fetch_cnt counts buffer pops.
  - perf_flush_cnt counts responses discarded by drop.
  - Both reset to 0 and wrap at 2^32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then imem_req_ready=1 with 1-cycle latency: no request in the WAIT cycle; addresses 0x80000000, 0x80000004, ... are issued one per cycle; inst_pc matches each inst.
- inst_ready=0 with BUF_DEPTH=2: exactly 2 requests are accepted, then imem_req_valid=0; inst holds the 0x80000000 word. Raising inst_ready restarts requests in the next cycle.
- Memory latency 3, redirect to 0x80000103 with 2 outstanding: pc becomes 0x80000100; FSM goes to FLUSH; 2 responses are discarded; next request is 0x80000100; no stale inst_valid.
- Redirect in the same cycle as a request handshake and a response: the accepted request is counted in drop, the response is dropped not pushed, and drop ends at the correct value.
- PC wrap with RESET_VEC=32'hFFFFFFFC: second request address is 0x00000000.
- Assert rst low mid-stream with a full buffer: inst_valid=0 and imem_req_valid=0 immediately. After release, one idle cycle, then the fetch at RESET_VEC. With FETCH_PERF_EN, both counters read 0.
